// File: rtl/cbfp_reorder_s1_if.sv
// Beat-level bus between the stage-0 CBFP normaliser, the stride-4 reorder buffer and stage 1.
// Carries 16-lane two's complement re/im samples plus a per-sample CBFP index in each direction.
// CBFP_BLKIDX_EN adds blk_index_out, the per-block minimum CBFP index.
interface cbfp_reorder_s1_if #(
    parameter int BW         = 11,
    parameter int IDX_W      = 5,
    parameter int BATCH_SIZE = 16
);
    // Each lane is a two's complement sample; lane l occupies [l*BW +: BW].
    logic [BATCH_SIZE-1:0][BW-1:0]    real_in;
    logic [BATCH_SIZE-1:0][BW-1:0]    imag_in;
    logic [BATCH_SIZE-1:0][IDX_W-1:0] index_in;
    logic                             in_valid;
    logic [BATCH_SIZE-1:0][BW-1:0]    real_out;
    logic [BATCH_SIZE-1:0][BW-1:0]    imag_out;
    logic [BATCH_SIZE-1:0][IDX_W-1:0] index_out;
    logic                             valid_out;
    logic                             overflow;
`ifdef CBFP_BLKIDX_EN
    logic [IDX_W-1:0]                 blk_index_out;
`endif

    modport master (
`ifdef CBFP_BLKIDX_EN
        input  blk_index_out,
`endif
        output real_in, imag_in, index_in, in_valid,
        input  real_out, imag_out, index_out, valid_out, overflow
    );

    modport slave (
`ifdef CBFP_BLKIDX_EN
        output blk_index_out,
`endif
        input  real_in, imag_in, index_in, in_valid,
        output real_out, imag_out, index_out, valid_out, overflow
    );
endinterface

// File: rtl/cbfp_reorder_s1.sv
// Purpose: ping-pong buffer that collects a 64-sample block (4 beats x 16 lanes) and re-emits it in stride-4 order.
// Latency: first output beat registered one cycle after the 4th input beat; 4 contiguous output beats follow.
// Backpressure: none; a block arriving while both banks are full is dropped whole and overflow sticks high.
// Optional: CBFP_BLKIDX_EN adds blk_index_out, the minimum CBFP index of the block being emitted.
module cbfp_reorder_s1 #(
    parameter int BW         = 11,
    parameter int IDX_W      = 5,
    parameter int BATCH_SIZE = 16,
    parameter int BLOCK_SIZE = 64
) (
    input logic              clk,
    input logic              rstn,
    cbfp_reorder_s1_if.slave bus
);
    localparam int NBEAT  = BLOCK_SIZE / BATCH_SIZE;
    localparam int BEAT_W = $clog2(NBEAT);
    localparam int LANE_W = $clog2(BATCH_SIZE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    logic [BW-1:0]    mem_re [2][BLOCK_SIZE];
    logic [BW-1:0]    mem_im [2][BLOCK_SIZE];
    logic [IDX_W-1:0] mem_ix [2][BLOCK_SIZE];

    logic [BEAT_W-1:0] wr_beat, drop_cnt, rd_beat;
    logic              wr_bank, rd_bank, dropping, overflow;
    logic [1:0]        bank_full;
    state_t            state, state_nxt;
    logic              wr_fire, drop_start, wr_done, emit, rd_done;

    logic [BATCH_SIZE-1:0][BW-1:0]    re_nxt, im_nxt, re_q, im_q;
    logic [BATCH_SIZE-1:0][IDX_W-1:0] ix_nxt, ix_q;
    logic                             vld_q;

    // Classify each incoming beat: store it, start dropping a block, or count it off a drop in progress
    always_comb begin
        drop_start = bus.in_valid && !dropping && (wr_beat == '0) && bank_full[wr_bank];
        wr_fire    = bus.in_valid && !dropping && !drop_start;
        wr_done    = wr_fire && (wr_beat == LAST_BEAT);
    end

    // Write pointer, drop tracking and sticky overflow flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_beat  <= '0;
            wr_bank  <= 1'b0;
            dropping <= 1'b0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_beat <= wr_done ? '0 : wr_beat + 1'b1;
                if (wr_done) wr_bank <= ~wr_bank;
            end
            // A dropped block still consumes 4 valid beats so the next block starts aligned.
            if (drop_start) begin
                dropping <= 1'b1;
                drop_cnt <= BEAT_W'(1);
                overflow <= 1'b1;
            end else if (bus.in_valid && dropping) begin
                drop_cnt <= drop_cnt + 1'b1;
                if (drop_cnt == LAST_BEAT) dropping <= 1'b0;
            end
        end
    end

    // Bank occupancy: set when a block finishes writing, cleared after its last beat is read
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_full <= 2'b00;
        end else begin
            if (wr_done) bank_full[wr_bank] <= 1'b1;
            if (rd_done) bank_full[rd_bank] <= 1'b0;
        end
    end

    // Sample storage: beat b lane l lands at sample 16b+l of the write bank
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int l = 0; l < BATCH_SIZE; l++) begin
                mem_re[wr_bank][{wr_beat, LANE_W'(l)}] <= bus.real_in[l];
                mem_im[wr_bank][{wr_beat, LANE_W'(l)}] <= bus.imag_in[l];
                mem_ix[wr_bank][{wr_beat, LANE_W'(l)}] <= bus.index_in[l];
            end
        end
    end

    // Read FSM state register with beat and bank pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rd_beat <= '0;
            rd_bank <= 1'b0;
        end else begin
            state <= state_nxt;
            if (emit) begin
                rd_beat <= rd_done ? '0 : rd_beat + 1'b1;
                if (rd_done) rd_bank <= ~rd_bank;
            end
        end
    end

    // Next state: stay in READ across block boundaries when the other bank is (or just became) full
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bank_full[rd_bank]) state_nxt = READ;
            READ:    if (rd_done && !bank_full[!rd_bank] && !wr_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: the first beat leaves straight from IDLE so a block costs no extra cycle
    always_comb begin
        emit   = 1'b0;
        re_nxt = '0;
        im_nxt = '0;
        ix_nxt = '0;
        case (state)
            IDLE:    emit = bank_full[rd_bank];
            READ:    emit = 1'b1;
            default: emit = 1'b0;
        endcase
        rd_done = emit && (rd_beat == LAST_BEAT);
        if (emit) begin
            for (int l = 0; l < BATCH_SIZE; l++) begin
                re_nxt[l] = mem_re[rd_bank][{LANE_W'(l), rd_beat}];
                im_nxt[l] = mem_im[rd_bank][{LANE_W'(l), rd_beat}];
                ix_nxt[l] = mem_ix[rd_bank][{LANE_W'(l), rd_beat}];
            end
        end
    end

    // Registered outputs; all-zero whenever no beat is being emitted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            re_q  <= '0;
            im_q  <= '0;
            ix_q  <= '0;
            vld_q <= 1'b0;
        end else begin
            re_q  <= re_nxt;
            im_q  <= im_nxt;
            ix_q  <= ix_nxt;
            vld_q <= emit;
        end
    end

    assign bus.real_out  = re_q;
    assign bus.imag_out  = im_q;
    assign bus.index_out = ix_q;
    assign bus.valid_out = vld_q;
    assign bus.overflow  = overflow;

`ifdef CBFP_BLKIDX_EN
    logic [IDX_W-1:0] beat_min, run_min, blk_cand, blk_q;
    logic [IDX_W-1:0] blk_min [2];

    // Smallest index in the current beat, folded into the running block minimum
    always_comb begin
        beat_min = '1;
        for (int l = 0; l < BATCH_SIZE; l++) begin
            if (bus.index_in[l] < beat_min) beat_min = bus.index_in[l];
        end
        blk_cand = ((wr_beat == '0) || (beat_min < run_min)) ? beat_min : run_min;
    end

    // Running minimum of the block being written
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) run_min <= '1;
        else if (wr_fire) run_min <= blk_cand;
    end

    // Per-bank block minimum, latched with the block's last beat
    always_ff @(posedge clk) begin
        if (wr_done) blk_min[wr_bank] <= blk_cand;
    end

    // Block minimum travels with every output beat of its block
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) blk_q <= '0;
        else blk_q <= emit ? blk_min[rd_bank] : '0;
    end

    assign bus.blk_index_out = blk_q;
`endif
endmodule

// File: doc/cbfp_reorder_s1.md
Name: cbfp_reorder_s1

Overview:
- Sits directly downstream of the stage-0 CBFP normaliser, between it and the stage-1 butterfly.
- Collects one 64-point block arriving as 4 beats of 16 lanes (11-bit re/im plus 5-bit CBFP index per sample).
- Re-emits the block as 4 beats in stride-4 order, the order stage 1 consumes.
- Ping-pong double buffer, so a new block can be written while the previous one is read out.

Parameters:
- BW, 11, data width of real/imag samples
- IDX_W, 5, width of per-sample CBFP index
- BATCH_SIZE, 16, lanes per beat
- BLOCK_SIZE, 64, samples per block (BLOCK_SIZE/BATCH_SIZE = 4 beats)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- real_in  in  signed BW x BATCH_SIZE  real samples of current input beat
- imag_in  in  signed BW x BATCH_SIZE  imag samples of current input beat
- index_in  in  IDX_W x BATCH_SIZE  CBFP index per sample
- in_valid  in  1  beat qualifier; one beat per high cycle
- real_out  out  signed BW x BATCH_SIZE  reordered real samples
- imag_out  out  signed BW x BATCH_SIZE  reordered imag samples
- index_out  out  IDX_W x BATCH_SIZE  index travelling with each sample
- valid_out  out  1  output beat qualifier
- overflow  out  1  sticky; a block was dropped because both banks were full

Behaviour:
- Reset (rstn low, async): all outputs 0; wr_beat=0, wr_bank=0, bank_full=2'b00, read FSM=IDLE, overflow=0. Buffer contents need not be cleared. Reset mid-block discards partial and pending blocks.
- Write side:
  - Input beat b (wr_beat, 0..3), lane l maps to sample n = 16b + l, stored at bank[wr_bank][n].
  - wr_beat increments per in_valid; beats of one block need not be contiguous (gaps allowed).
  - On beat 3: bank_full[wr_bank] set, wr_bank toggles, wr_beat wraps to 0.
- Write-side overflow:
  - If in_valid arrives with wr_beat==0 while bank_full[wr_bank]==1, the whole incoming block (4 valid beats) is dropped.
  - overflow is set and held until reset; the bank is not disturbed.
  - Dropping is tracked by a drop counter so alignment is kept.
- Read FSM, states IDLE and READ:
  - IDLE -> READ when bank_full[rd_bank]==1. rd_beat=0.
  - READ: output beat c (rd_beat), lane l = bank[rd_bank][4l + c], applied to real_out/imag_out/index_out, registered. valid_out=1.
  - After c==3: clear bank_full[rd_bank], toggle rd_bank. Go to READ again if the other bank is already full (back-to-back, no bubble); otherwise go to IDLE.
- Outputs are 0 whenever valid_out=0.
- Latency: 4th input beat sampled at edge k -> first output beat (c=0) valid after edge k+1. Beats c=1..3 follow on consecutive cycles, 4 contiguous cycles of valid_out.
- Simultaneous events:
  - Write of beat 3 into bank X and read completion of bank Y in the same cycle is legal.
  - A set and clear of the same bank_full bit in one cycle cannot occur (different banks).
  - A write into a bank being read cannot occur, since bank_full blocks it.
- Steady state: continuous input at 1 beat/cycle never overflows.
- Data and index pass unmodified; no arithmetic on samples.

Optional Feature:
- Macro: CBFP_BLKIDX_EN.
- Defined:
  - Adds output port blk_index_out [IDX_W-1:0], the minimum index_in over all 64 samples of the block, computed incrementally during writes and stored per bank.
  - Driven alongside all 4 output beats; 0 when valid_out=0 and at reset.
- Undefined: port and min logic absent; all other behaviour identical.

Test Plan:
- Single block: beat b lane l input real=16b+l, imag=-(16b+l), index=3 -> 4 valid_out cycles starting 1 cycle after beat 3; out beat c lane l real=4l+c, imag=-(4l+c), index=3.
- Back-to-back: 3 blocks with in_valid held high 12 cycles, block-tagged data -> 12 contiguous valid_out cycles, correct per-block permutation, overflow=0.
- Gapped input: in_valid pattern 1,0,0,1,1,0,1 -> output begins 1 cycle after the 4th valid beat, content as in the single-block scenario.
- Overflow: hold output side by sending 3 blocks with gaps such that both banks full, by presenting the 3rd block while the 1st is still being read (force via fast write of 12 beats) -> confirm no overflow; then sustain 1 beat/cycle and verify overflow stays 0. Separately, inject a 3rd block during reset-release with both banks full (via force) -> block dropped, overflow=1 sticky.
- Reset mid-operation: assert rstn low after beat 2 of a block, release, send fresh block -> no stale output, outputs 0 during reset, new block output correct.
- CBFP_BLKIDX_EN: indices 7 everywhere except sample 37 = 2 -> blk_index_out=2 on all 4 output beats, 0 otherwise.
